// File: rtl/axil_pkg.sv
// Shared UART framing constants, used by the RX/TX blocks and the TX arbiter.
package axil_pkg;

    // Width of one UART frame word carried on the AXI-Stream links.
    localparam int FRAME_W = 72;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/axis_if_uart.sv
// AXI-Stream link carrying one UART frame per beat.
interface axis_if_uart;
    import axil_pkg::*;

    frame_t tdata;
    logic   tvalid;
    logic   tready;

    modport s_axis (input tdata, input tvalid, output tready);
    modport m_axis (output tdata, output tvalid, input tready);

endinterface

// File: rtl/axis_uart_tx_arb.sv
// Two-input frame arbiter in front of the UART transmitter.
// A frame is captured into a one-deep output register (IDLE -> SEND) and
// held until the transmitter takes it, so at most one frame per two cycles
// is accepted. Input tready never looks at m_axis.tready.
module axis_uart_tx_arb
    import axil_pkg::*;
#(
    parameter int ARB_MODE = 0,   // 0 = round-robin, 1 = fixed priority (s0 first)
    parameter int CNT_W    = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    axis_if_uart.s_axis      s0_axis,
    axis_if_uart.s_axis      s1_axis,
    axis_if_uart.m_axis      m_axis,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        last_grant_reg;
    frame_t      tdata_reg;
    logic        tvalid_reg;

    logic        sel;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [1:0]  s_hs;
    logic        m_hs;

    assign s_valid = {s1_axis.tvalid, s0_axis.tvalid};
    assign s_hs    = s_ready & s_valid;
    assign m_hs    = tvalid_reg & m_axis.tready;

    // Pick a requester: round-robin only matters when both are asking;
    // otherwise the single valid port wins (s0 when s0 is valid).
    always_comb begin
        sel = ~s_valid[0];
        if ((ARB_MODE == 0) && (s_valid == 2'b11)) begin
            sel = ~last_grant_reg;
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: capture on an input handshake, release on output handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|s_hs) state_next = SEND;
            SEND:    if (m_hs)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state: only the selected, valid port sees tready.
    always_comb begin
        s_ready = 2'b00;
        busy    = (state_reg == SEND);
        if (aresetn && (state_reg == IDLE)) begin
            s_ready[0] = ~sel & s_valid[0];
            s_ready[1] =  sel & s_valid[1];
        end
    end

    // Output frame register and arbitration history.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if ((state_reg == IDLE) && (|s_hs)) begin
            tdata_reg      <= sel ? s1_axis.tdata : s0_axis.tdata;
            tvalid_reg     <= 1'b1;
            last_grant_reg <= sel;
        end else if ((state_reg == SEND) && m_hs) begin
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
        end
    end

    // Per-port accepted-frame counters, free-running with wrap.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Count one per accepted handshake on this port.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    cnt_reg <= '0;
                end else if (s_hs[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign cnt0           = gen_cnt[0].cnt_reg;
    assign cnt1           = gen_cnt[1].cnt_reg;
    assign s0_axis.tready = s_ready[0];
    assign s1_axis.tready = s_ready[1];
    assign m_axis.tdata   = tdata_reg;
    assign m_axis.tvalid  = tvalid_reg;

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// Directed bench for axis_uart_tx_arb: a round-robin instance with 4-bit
// counters and a fixed-priority instance with default counters.
module tb_axis_uart_tx_arb;
    import axil_pkg::*;

    logic aclk;
    logic aresetn;
    int   total;
    int   passed;

    logic [3:0]  a_cnt0, a_cnt1;
    logic        a_busy;
    logic [15:0] b_cnt0, b_cnt1;
    logic        b_busy;

    localparam logic [71:0] D  = 72'h11_2233_4455_6677_8899;
    localparam logic [71:0] D0 = 72'hA0_A1A2_A3A4_A5A6_A7A8;
    localparam logic [71:0] D1 = 72'hB0_B1B2_B3B4_B5B6_B7B8;

    axis_if_uart a_s0();
    axis_if_uart a_s1();
    axis_if_uart a_m();
    axis_if_uart b_s0();
    axis_if_uart b_s1();
    axis_if_uart b_m();

    axis_uart_tx_arb #(.ARB_MODE(0), .CNT_W(4)) dut_a (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0_axis (a_s0),
        .s1_axis (a_s1),
        .m_axis  (a_m),
        .cnt0    (a_cnt0),
        .cnt1    (a_cnt1),
        .busy    (a_busy)
    );

    axis_uart_tx_arb #(.ARB_MODE(1), .CNT_W(16)) dut_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0_axis (b_s0),
        .s1_axis (b_s1),
        .m_axis  (b_m),
        .cnt0    (b_cnt0),
        .cnt1    (b_cnt1),
        .busy    (b_busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        total = 0;
        passed = 0;
        aresetn = 1'b0;
        a_s0.tdata = '0; a_s0.tvalid = 1'b0;
        a_s1.tdata = '0; a_s1.tvalid = 1'b0;
        a_m.tready = 1'b0;
        b_s0.tdata = '0; b_s0.tvalid = 1'b0;
        b_s1.tdata = '0; b_s1.tvalid = 1'b0;
        b_m.tready = 1'b0;

        // Reset: tready held low even with a valid request
        a_s0.tvalid = 1'b1;
        tick();
        tick();
        chk("rst_tready0", a_s0.tready, 1'b0);
        a_s0.tvalid = 1'b0;
        aresetn = 1'b1;
        chk("rst_m_tvalid", a_m.tvalid, 1'b0);
        chk("rst_m_tdata", a_m.tdata, 72'h0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_cnt0", a_cnt0, 4'd0);
        chk("rst_cnt1", a_cnt1, 4'd0);
        $display("txn reset done");

        // Single frame from s0
        a_m.tready = 1'b1;
        a_s0.tdata = D;
        a_s0.tvalid = 1'b1;
        #1;
        chk("single_tready0", a_s0.tready, 1'b1);
        chk("single_tready1", a_s1.tready, 1'b0);
        tick();
        chk("single_tready0_send", a_s0.tready, 1'b0);
        chk("single_m_tvalid", a_m.tvalid, 1'b1);
        chk("single_m_tdata", a_m.tdata, D);
        chk("single_busy", a_busy, 1'b1);
        chk("single_cnt0", a_cnt0, 4'd1);
        chk("single_cnt1", a_cnt1, 4'd0);
        a_s0.tvalid = 1'b0;
        tick();
        chk("single_m_tvalid_clr", a_m.tvalid, 1'b0);
        chk("single_m_tdata_clr", a_m.tdata, 72'h0);
        chk("single_busy_clr", a_busy, 1'b0);
        $display("txn single s0 frame tdata=%0h", D);

        // No requests: stay idle; request withdrawn before the edge is ignored
        chk("idle_tready0", a_s0.tready, 1'b0);
        chk("idle_tready1", a_s1.tready, 1'b0);
        tick();
        chk("idle_busy", a_busy, 1'b0);
        a_s0.tvalid = 1'b1;
        #1;
        chk("drop_tready_before", a_s0.tready, 1'b1);
        #2;
        a_s0.tvalid = 1'b0;
        #1;
        chk("drop_tready_after", a_s0.tready, 1'b0);
        tick();
        chk("drop_m_tvalid", a_m.tvalid, 1'b0);
        chk("drop_cnt0", a_cnt0, 4'd1);
        $display("txn idle and withdrawn request");

        // Round-robin with both requesting continuously
        do_reset();
        a_s0.tdata = D0;
        a_s1.tdata = D1;
        a_s0.tvalid = 1'b1;
        a_s1.tvalid = 1'b1;
        a_m.tready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_tready0", a_s0.tready, logic'(k % 2 == 0));
            chk("rr_tready1", a_s1.tready, logic'(k % 2 == 1));
            tick();
            chk("rr_m_tdata", a_m.tdata, (k % 2 == 0) ? D0 : D1);
            $display("txn rr frame %0d tdata=%0h", k, a_m.tdata);
            tick();
        end
        chk("rr_cnt0", a_cnt0, 4'd2);
        chk("rr_cnt1", a_cnt1, 4'd2);

        // Output stall for 10 cycles while both still request
        a_m.tready = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("stall_m_tvalid", a_m.tvalid, 1'b1);
            chk("stall_m_tdata", a_m.tdata, D0);
            chk("stall_tready0", a_s0.tready, 1'b0);
            chk("stall_tready1", a_s1.tready, 1'b0);
            chk("stall_busy", a_busy, 1'b1);
            tick();
        end
        a_m.tready = 1'b1;
        tick();
        chk("stall_release_tvalid", a_m.tvalid, 1'b0);
        chk("stall_cnt0", a_cnt0, 4'd3);
        a_s0.tvalid = 1'b0;
        a_s1.tvalid = 1'b0;
        $display("txn stall 10 cycles tdata=%0h", D0);

        // Reset while a frame is held
        a_m.tready = 1'b0;
        a_s1.tvalid = 1'b1;
        tick();
        chk("rstsend_held", a_m.tdata, D1);
        a_s1.tvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        chk("rstsend_m_tvalid", a_m.tvalid, 1'b0);
        chk("rstsend_m_tdata", a_m.tdata, 72'h0);
        chk("rstsend_busy", a_busy, 1'b0);
        chk("rstsend_cnt0", a_cnt0, 4'd0);
        chk("rstsend_cnt1", a_cnt1, 4'd0);
        aresetn = 1'b1;
        a_m.tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rstsend_no_replay", a_m.tvalid, 1'b0);
        end
        $display("txn reset during send");

        // Counter wrap: 17 frames on s1 with a 4-bit counter
        a_s1.tvalid = 1'b1;
        for (int k = 0; k < 34; k++) begin
            tick();
        end
        chk("wrap_cnt1", a_cnt1, 4'd1);
        chk("wrap_cnt0", a_cnt0, 4'd0);
        a_s1.tvalid = 1'b0;
        $display("txn 17 s1 frames cnt1=%0d", a_cnt1);

        // Fixed priority: s0 always wins
        b_s0.tdata = D0;
        b_s1.tdata = D1;
        b_s0.tvalid = 1'b1;
        b_s1.tvalid = 1'b1;
        b_m.tready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("fix_tready0", b_s0.tready, 1'b1);
            chk("fix_tready1", b_s1.tready, 1'b0);
            tick();
            chk("fix_m_tdata", b_m.tdata, D0);
            $display("txn fixed frame %0d tdata=%0h", k, b_m.tdata);
            tick();
        end
        chk("fix_cnt0", b_cnt0, 16'd4);
        chk("fix_cnt1", b_cnt1, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axis_uart_tx_arb.md
AXIS_UART_TX_ARB -- requirements
Module: axis_uart_tx_arb

Interface
REQ-001 The block SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority with s0 highest.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the per-port frame counters.
REQ-003 aclk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 s0_axis  axis_if_uart.s_axis  tdata 72 / tvalid 1 / tready 1  requester 0 frame stream (response frames).
REQ-006 s1_axis  axis_if_uart.s_axis  tdata 72 / tvalid 1 / tready 1  requester 1 frame stream (status/error frames).
REQ-007 m_axis  axis_if_uart.m_axis  tdata 72 / tvalid 1 / tready 1  arbitrated frame stream to the UART transmitter.
REQ-008 cnt0, cnt1  output  CNT_W each  count of frames accepted from s0 and s1 respectively.
REQ-009 busy  output  1  high whenever state is SEND.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-011 In IDLE, sel SHALL be computed combinationally from s0/s1 tvalid, ARB_MODE and last_grant.
REQ-012 In IDLE, sx_axis.tready SHALL equal (sel==x) && sx_axis.tvalid, combinationally; the non-selected port's tready SHALL be 0.
REQ-013 On an IDLE handshake, tdata SHALL be latched into m_axis.tdata and m_axis.tvalid SHALL go 1 on the next cycle, with the state moving to SEND (latency 1 cycle).
REQ-014 In SEND, both s tready SHALL be 0 and m_axis.tdata SHALL be held stable.
REQ-015 A SEND-state handshake (m_axis.tvalid && m_axis.tready) SHALL clear m_axis.tvalid and m_axis.tdata to 0 and move the state to IDLE.
REQ-016 Frames SHALL be accepted at most once per 2 cycles; there SHALL be no bypass from IDLE.
REQ-017 Round-robin mode: with both valid, the port not equal to last_grant SHALL win.
REQ-018 Round-robin mode: with one valid, that port SHALL win.
REQ-019 Round-robin mode: last_grant SHALL update only on an accepted s-handshake.
REQ-020 Fixed mode: s0 SHALL win whenever s0 tvalid=1, regardless of last_grant.
REQ-021 With no s tvalid in IDLE, the block SHALL stay in IDLE, keep all tready=0 and leave last_grant unchanged.
REQ-022 A requester dropping tvalid before its handshake SHALL NOT be accepted; no latching and no counter change SHALL occur.
REQ-023 cntX SHALL increment by 1 on each sX handshake and SHALL wrap from 2^CNT_W-1 to 0 without saturation.
REQ-024 s tready SHALL NOT depend on m_axis.tready, so there is no combinational path from m_axis.tready to any s port.

Reset
REQ-025 On aresetn=0 the block SHALL set state=IDLE, m_axis.tvalid=0, m_axis.tdata=0, last_grant=1 (so s0 wins first), cnt0=cnt1=0 and busy=0.
REQ-026 Reset asserted during SEND SHALL drop the pending frame silently, with no retransmit after release.
REQ-027 While aresetn=0, all s tready SHALL read 0.

Structure
REQ-028 The 72-bit frame width constant SHALL live in axil_pkg, shared with the UART RX/TX blocks.
REQ-029 The state enum and last_grant SHALL be local to the module.
REQ-030 The design SHALL be a single module with no sub-module; the two-way arbiter is small enough to be inline.

Verification
REQ-031 s0 only, tdata=72'h11_2233_4455_6677_8899, m_tready=1 -> s0 tready pulses 1 cycle; m_tvalid high 1 cycle later with identical tdata; cnt0=1, cnt1=0.
REQ-032 Both valid continuously, ARB_MODE=0, m_tready=1 -> grants s0, s1, s0, s1 (first grant s0 after reset); cnt0=cnt1=2 after 4 frames.
REQ-033 Both valid continuously, ARB_MODE=1 -> 4 consecutive s0 grants; cnt1 stays 0.
REQ-034 m_tready=0 for 10 cycles during SEND -> m_tvalid and tdata stable for all 10 cycles; s tready=0 throughout; busy=1.
REQ-035 aresetn pulsed low during SEND -> next cycle m_tvalid=0, state IDLE, counters 0; the held frame never appears on m_axis.
REQ-036 CNT_W=4, 17 s1 frames -> cnt1 wraps to 1.
